// File: rtl/stg5wb_if.sv
// stg5wb bundle: memory-stage result in, register-file writes out.
// Ports: iw_* driven by master (upstream), ow_* driven by slave (stage).
interface stg5wb_if #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 24,
  parameter int OPC_W    = 8,
  parameter int GP_IDX_W = 4,
  parameter int SR_IDX_W = 2,
  parameter int RET_W    = 32
);
  logic [ADDR_W-1:0]   iw_pc;
  logic [DATA_W-1:0]   iw_instr;
  logic [OPC_W-1:0]    iw_opc;
  logic [GP_IDX_W:0]   iw_tgt_gp;
  logic [SR_IDX_W:0]   iw_tgt_sr;
  logic [DATA_W-1:0]   iw_result;
  logic                iw_resume;
  logic                ow_gp_we;
  logic [GP_IDX_W-1:0] ow_gp_addr;
  logic [DATA_W-1:0]   ow_gp_data;
  logic                ow_sr_we;
  logic [SR_IDX_W-1:0] ow_sr_addr;
  logic [DATA_W-1:0]   ow_sr_data;
  logic [ADDR_W-1:0]   ow_pc;
  logic [DATA_W-1:0]   ow_instr;
  logic [RET_W-1:0]    ow_retired;
  logic                ow_halt;

  modport master (
    output iw_pc, iw_instr, iw_opc, iw_tgt_gp,
    output iw_tgt_sr, iw_result, iw_resume,
    input  ow_gp_we, ow_gp_addr, ow_gp_data,
    input  ow_sr_we, ow_sr_addr, ow_sr_data,
    input  ow_pc, ow_instr, ow_retired, ow_halt
  );

  modport slave (
    input  iw_pc, iw_instr, iw_opc, iw_tgt_gp,
    input  iw_tgt_sr, iw_result, iw_resume,
    output ow_gp_we, ow_gp_addr, ow_gp_data,
    output ow_sr_we, ow_sr_addr, ow_sr_data,
    output ow_pc, ow_instr, ow_retired, ow_halt
  );
endinterface

// File: rtl/stg5wb.sv
// Write-back stage: registered GP/SR write strobes, retire count, halt FSM.
// Ports: iw_clk, iw_rst_n (async low), bus (stg5wb_if.slave).
module stg5wb #(
  parameter int              ADDR_W   = 24,
  parameter int              DATA_W   = 24,
  parameter int              OPC_W    = 8,
  parameter int              GP_IDX_W = 4,
  parameter int              SR_IDX_W = 2,
  parameter int              RET_W    = 32,
  parameter logic [OPC_W-1:0] OPC_NOP = 8'h00,
  parameter logic [OPC_W-1:0] OPC_HLT = 8'hFF
) (
  input logic     iw_clk,
  input logic     iw_rst_n,
  stg5wb_if.slave bus
);

  typedef enum logic {
    S_RUN,
    S_HALTED
  } state_t;

  state_t              state_q;
  logic                gp_we_q;
  logic [GP_IDX_W-1:0] gp_addr_q;
  logic [DATA_W-1:0]   gp_data_q;
  logic                sr_we_q;
  logic [SR_IDX_W-1:0] sr_addr_q;
  logic [DATA_W-1:0]   sr_data_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   instr_q;
  logic [RET_W-1:0]    ret_q;
  logic                halt_q;

  logic is_nop, is_hlt, gp_we_d, sr_we_d;

  assign is_nop  = bus.iw_opc == OPC_NOP;
  assign is_hlt  = bus.iw_opc == OPC_HLT;
  // NOP and HLT never write, whatever their targets say
  assign gp_we_d = bus.iw_tgt_gp[GP_IDX_W] & ~is_nop & ~is_hlt;
  assign sr_we_d = bus.iw_tgt_sr[SR_IDX_W] & ~is_nop & ~is_hlt;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q   <= S_RUN;
      gp_we_q   <= 1'b0;
      gp_addr_q <= '0;
      gp_data_q <= '0;
      sr_we_q   <= 1'b0;
      sr_addr_q <= '0;
      sr_data_q <= '0;
      pc_q      <= '0;
      instr_q   <= '0;
      ret_q     <= '0;
      halt_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          gp_we_q <= gp_we_d;
          sr_we_q <= sr_we_d;
          if (gp_we_d) begin
            gp_addr_q <= bus.iw_tgt_gp[GP_IDX_W-1:0];
            gp_data_q <= bus.iw_result;
          end
          if (sr_we_d) begin
            sr_addr_q <= bus.iw_tgt_sr[SR_IDX_W-1:0];
            sr_data_q <= bus.iw_result;
          end
          if (!is_nop) begin
            ret_q   <= ret_q + RET_W'(1);
            pc_q    <= bus.iw_pc;
            instr_q <= bus.iw_instr;
          end
          // resume is meaningless here; HLT alone decides
          if (is_hlt) begin
            state_q <= S_HALTED;
            halt_q  <= 1'b1;
          end
        end
        S_HALTED: begin
          // input on the resume edge is still dropped
          gp_we_q <= 1'b0;
          sr_we_q <= 1'b0;
          if (bus.iw_resume) begin
            state_q <= S_RUN;
            halt_q  <= 1'b0;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign bus.ow_gp_we   = gp_we_q;
  assign bus.ow_gp_addr = gp_addr_q;
  assign bus.ow_gp_data = gp_data_q;
  assign bus.ow_sr_we   = sr_we_q;
  assign bus.ow_sr_addr = sr_addr_q;
  assign bus.ow_sr_data = sr_data_q;
  assign bus.ow_pc      = pc_q;
  assign bus.ow_instr   = instr_q;
  assign bus.ow_retired = ret_q;
  assign bus.ow_halt    = halt_q;

endmodule

// File: tb/tb_stg5wb.sv
// Scoreboard bench for stg5wb: directed plan plus random traffic.
// Retire counter narrowed to 4 bits so wrap is reachable.
module tb_stg5wb;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stg5wb_if #(.RET_W(RW)) bus ();

  stg5wb #(.RET_W(RW)) dut (
    .iw_clk   (clk),
    .iw_rst_n (rst_n),
    .bus      (bus)
  );

  typedef struct {
    int          due;
    bit          gp_we;
    bit [3:0]    gp_addr;
    bit [23:0]   gp_data;
    bit          sr_we;
    bit [1:0]    sr_addr;
    bit [23:0]   sr_data;
    bit [23:0]   pc;
    bit [23:0]   instr;
    int          ret;
    bit          halt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, a, e);
  endtask

  task automatic m_reset();
    m = '{default: 0};
  endtask

  // Reference: apply the write-back rules to one presented instruction
  task automatic drv(input bit [7:0] opc, input bit [4:0] gp,
                     input bit [2:0] sr, input bit [23:0] res,
                     input bit [23:0] pc, input bit rsm);
    bit [23:0] ins;
    ins = 24'($urandom);
    bus.iw_opc    = opc;
    bus.iw_tgt_gp = gp;
    bus.iw_tgt_sr = sr;
    bus.iw_result = res;
    bus.iw_pc     = pc;
    bus.iw_instr  = ins;
    bus.iw_resume = rsm;
    if (m.halt) begin
      m.gp_we = 0;
      m.sr_we = 0;
      if (rsm) m.halt = 0;
    end else begin
      m.gp_we = gp[4] && opc != 8'h00 && opc != 8'hFF;
      m.sr_we = sr[2] && opc != 8'h00 && opc != 8'hFF;
      if (m.gp_we) begin m.gp_addr = gp[3:0]; m.gp_data = res; end
      if (m.sr_we) begin m.sr_addr = sr[1:0]; m.sr_data = res; end
      if (opc != 8'h00) begin
        m.ret   = (m.ret + 1) % (1 << RW);
        m.pc    = pc;
        m.instr = ins;
      end
      if (opc == 8'hFF) m.halt = 1;
    end
    m.due = cyc + 1;
    q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      chk("late_entry", 64'(q[0].due), 64'(cyc));
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("gp_we",   64'(bus.ow_gp_we),   64'(e.gp_we));
      chk("gp_addr", 64'(bus.ow_gp_addr), 64'(e.gp_addr));
      chk("gp_data", 64'(bus.ow_gp_data), 64'(e.gp_data));
      chk("sr_we",   64'(bus.ow_sr_we),   64'(e.sr_we));
      chk("sr_addr", 64'(bus.ow_sr_addr), 64'(e.sr_addr));
      chk("sr_data", 64'(bus.ow_sr_data), 64'(e.sr_data));
      chk("pc",      64'(bus.ow_pc),      64'(e.pc));
      chk("instr",   64'(bus.ow_instr),   64'(e.instr));
      chk("retired", 64'(bus.ow_retired), 64'(e.ret));
      chk("halt",    64'(bus.ow_halt),    64'(e.halt));
    end
  end

  task automatic chk_zero(input string n);
    chk({n, "_gp_we"}, 64'(bus.ow_gp_we), 0);
    chk({n, "_sr_we"}, 64'(bus.ow_sr_we), 0);
    chk({n, "_ret"},   64'(bus.ow_retired), 0);
    chk({n, "_halt"},  64'(bus.ow_halt), 0);
    chk({n, "_pc"},    64'(bus.ow_pc), 0);
  endtask

  task automatic rnd_cycle();
    int r;
    bit [7:0] op;
    r = int'($urandom_range(0, 99));
    if (r < 20) op = 8'h00;
    else if (r < 26) op = 8'hFF;
    else op = 8'($urandom_range(1, 254));
    drv(op, 5'($urandom), 3'($urandom), 24'($urandom),
        24'($urandom), $urandom_range(0, 3) == 0);
  endtask

  initial begin
    bus.iw_opc = '0;
    bus.iw_tgt_gp = '0;
    bus.iw_tgt_sr = '0;
    bus.iw_result = '0;
    bus.iw_pc = '0;
    bus.iw_instr = '0;
    bus.iw_resume = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    drv(8'h10, 5'b1_0011, 3'b0_00, 24'hABCDEF, 24'h000100, 0);
    chk("t1_gp_addr", 64'(bus.ow_gp_addr), 3);
    chk("t1_ret", 64'(bus.ow_retired), 1);
    drv(8'h00, 5'b0_0000, 3'b0_00, 24'h0, 24'h0, 0);
    drv(8'h20, 5'b1_0101, 3'b1_10, 24'h000042, 24'h000104, 0);
    drv(8'h00, 5'b1_0001, 3'b0_00, 24'h111111, 24'h000108, 0);
    drv(8'hFF, 5'b1_0010, 3'b1_01, 24'h222222, 24'h000200, 0);
    chk("hlt_halt", 64'(bus.ow_halt), 1);
    chk("hlt_gp_we", 64'(bus.ow_gp_we), 0);
    for (int i = 0; i < 3; i++)
      drv(8'h30, 5'b1_0110, 3'b1_11, 24'h333333, 24'h000204, 0);
    drv(8'h31, 5'b1_0111, 3'b0_00, 24'h444444, 24'h000208, 1);
    chk("rsm_drop", 64'(bus.ow_gp_we), 0);
    drv(8'h32, 5'b1_1000, 3'b0_00, 24'h555555, 24'h00020C, 0);
    chk("rsm_next", 64'(bus.ow_gp_we), 1);

    while (m.ret != (1 << RW) - 1)
      drv(8'h40, 5'b0_0000, 3'b0_00, 24'h0, 24'h000300, 0);
    drv(8'h41, 5'b1_0001, 3'b0_00, 24'h666666, 24'h000304, 0);
    chk("wrap", 64'(bus.ow_retired), 0);

    for (int i = 0; i < 300; i++) rnd_cycle();
    if (m.halt) drv(8'h00, 5'b0, 3'b0, 24'h0, 24'h0, 1);

    drv(8'hFF, 5'b0_0000, 3'b0_00, 24'h0, 24'h000400, 0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_reset();
    chk_zero("arst");
    bus.iw_opc = 8'h00;
    @(posedge clk);
    #2 rst_n = 1'b1;
    drv(8'h50, 5'b1_1001, 3'b0_00, 24'h777777, 24'h000500, 0);
    chk("post_rst_we", 64'(bus.ow_gp_we), 1);
    chk("post_rst_ret", 64'(bus.ow_retired), 1);
    for (int i = 0; i < 50; i++) rnd_cycle();

    repeat (3) @(posedge clk);
    if (q.size() != 0) chk("q_drained", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
